// File: rtl/path_history_folder.sv
// Folds the path history into a FOLD_LEN-bit value, updated one history write per cycle.
// A serial scan rebuilds the folded value from the full history when resync is pulsed.
module path_history_folder #(
  parameter int PHIST_LEN = 16,
  parameter int FOLD_LEN  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [31:0]          pc,
  input  logic [PHIST_LEN-1:0] rdata_phist,
  input  logic                 resync,
  output logic [FOLD_LEN-1:0]  folded,
  output logic                 valid
);

  // state | meaning
  // READY | folded tracks history incrementally, valid=1
  // SCAN  | serial rebuild from rdata_phist, valid=0, folded held

  localparam int CNT_W    = $clog2(PHIST_LEN) + 1;
  localparam int IDX_W    = (PHIST_LEN > 1) ? $clog2(PHIST_LEN) : 1;
  localparam int DROP_POS = PHIST_LEN % FOLD_LEN;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PHIST_LEN - 1);

  typedef enum logic {READY, SCAN} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FOLD_LEN-1:0] acc_q, acc_d;
  logic [FOLD_LEN-1:0] folded_q, folded_d;
  logic                valid_q, valid_d;
  logic [FOLD_LEN-1:0] ins_bits;
  logic [FOLD_LEN-1:0] scan_bit;
  logic [FOLD_LEN-1:0] scan_next;
  logic                unused_pc;

  assign unused_pc = ^{pc[31:3], pc[1:0]};

  function automatic logic [FOLD_LEN-1:0] rotl1(input logic [FOLD_LEN-1:0] x);
    logic [FOLD_LEN-1:0] r;
    r = '0;
    for (int i = 0; i < FOLD_LEN; i++) r[(i + 1) % FOLD_LEN] = x[i];
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= READY;
      cnt_q    <= '0;
      acc_q    <= '0;
      folded_q <= '0;
      valid_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      folded_q <= folded_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    folded_d = folded_q;
    valid_d  = valid_q;

    // New bit enters at position 0; the bit leaving the window lands at PHIST_LEN mod FOLD_LEN.
    ins_bits           = '0;
    ins_bits[0]        = pc[2];
    ins_bits[DROP_POS] = ins_bits[DROP_POS] ^ rdata_phist[0];

    scan_bit    = '0;
    scan_bit[0] = rdata_phist[cnt_q[IDX_W-1:0]];
    scan_next   = rotl1(acc_q) ^ scan_bit;

    case (state_q)
      READY: begin
        if (resync) begin
          state_d = SCAN;
          cnt_d   = '0;
          acc_d   = '0;
          valid_d = 1'b0;
        end else if (we) begin
          folded_d = rotl1(folded_q) ^ ins_bits;
        end
      end
      SCAN: begin
        if (we || resync) begin
          cnt_d = '0;
          acc_d = '0;
        end else begin
          acc_d = scan_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            folded_d = scan_next;
            valid_d  = 1'b1;
            state_d  = READY;
          end
        end
      end
      default: state_d = READY;
    endcase
  end

  assign folded = folded_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_path_history_folder.sv
// Directed bench for path_history_folder with a local model of the history writer.
module tb_path_history_folder;

  logic        clk;
  logic        rst;
  logic        wrst;
  logic        we;
  logic [31:0] pc;
  logic        resync;
  logic [15:0] phist;
  logic [9:0]  folded;
  logic        valid;

  int vectors;
  int miscompares;

  path_history_folder #(.PHIST_LEN(16), .FOLD_LEN(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .pc         (pc),
    .rdata_phist(phist),
    .resync     (resync),
    .folded     (folded),
    .valid      (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge wrst) begin
    if (wrst) phist <= '0;
    else if (we) phist <= {pc[2], phist[15:1]};
  end

  function automatic logic [9:0] fold_def(input logic [15:0] h);
    logic [9:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i % 10] = r[i % 10] ^ h[15 - i];
    return r;
  endfunction

  // Called at a negedge; drives inputs for the next posedge and returns at the following negedge.
  task automatic step(input logic w, input logic [31:0] p, input logic r);
    we = w; pc = p; resync = r;
    @(negedge clk);
    we = 1'b0; resync = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; wrst = 1'b1;
    #1;
    rst = 1'b0; wrst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; wrst = 1'b1;
    step(1'b1, 32'h4, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    vectors++;
    if (folded !== 10'h000) begin
      miscompares++;
      $display("FAIL reset_folded: got %h expected %h", folded, 10'h000);
    end
    vectors++;
    if (valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_valid: got %b expected %b", valid, 1'b1);
    end
    rst = 1'b0; wrst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_we();
    do_reset();
    step(1'b1, 32'h4, 1'b0);
    vectors++;
    if (folded !== 10'h001 || valid !== 1'b1) begin
      miscompares++;
      $display("FAIL single_we: got folded=%h valid=%b expected 001/1", folded, valid);
    end
    step(1'b1, 32'h0, 1'b0);
    vectors++;
    if (folded !== 10'h002) begin
      miscompares++;
      $display("FAIL single_we_shift: got %h expected %h", folded, 10'h002);
    end
  endtask

  task automatic test_all_ones();
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 32'h4, 1'b0);
    vectors++;
    if (folded !== 10'h3FF) begin
      miscompares++;
      $display("FAIL ones_10: got %h expected %h", folded, 10'h3FF);
    end
    for (int i = 0; i < 6; i++) step(1'b1, 32'h4, 1'b0);
    vectors++;
    if (folded !== 10'h3C0) begin
      miscompares++;
      $display("FAIL ones_16: got %h expected %h", folded, 10'h3C0);
    end
    for (int i = 0; i < 10; i++) step(1'b1, 32'hFFFF_FFFF, 1'b0);
    vectors++;
    if (folded !== 10'h3C0 || valid !== 1'b1) begin
      miscompares++;
      $display("FAIL ones_26: got folded=%h valid=%b expected 3c0/1", folded, valid);
    end
  endtask

  task automatic test_random();
    logic [9:0] exp_f;
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'b0);
      exp_f = fold_def(phist);
      vectors++;
      if (valid !== 1'b1 || folded !== exp_f) begin
        miscompares++;
        $display("FAIL random[%0d]: got folded=%h valid=%b expected %h/1", i, folded, valid, exp_f);
      end
    end
  endtask

  task automatic load_history(input logic [15:0] pat);
    for (int i = 0; i < 16; i++) step(1'b1, {29'b0, pat[i], 2'b0}, 1'b0);
  endtask

  task automatic test_resync();
    logic [9:0] exp_f;
    do_reset();
    load_history(16'hA5C3);
    // Reset only the folder so its value disagrees with the history.
    rst = 1'b1; #1; rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (folded !== 10'h000) begin
      miscompares++;
      $display("FAIL resync_pre: got %h expected %h", folded, 10'h000);
    end
    step(1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (valid !== 1'b0 || folded !== 10'h000) begin
        miscompares++;
        $display("FAIL resync_scan[%0d]: got valid=%b folded=%h expected 0/000", k, valid, folded);
      end
      step(1'b0, 32'h0, 1'b0);
    end
    exp_f = fold_def(phist);
    vectors++;
    if (valid !== 1'b1 || folded !== exp_f) begin
      miscompares++;
      $display("FAIL resync_done: got folded=%h valid=%b expected %h/1", folded, valid, exp_f);
    end
  endtask

  task automatic test_restart();
    logic [9:0] exp_f;
    logic [9:0] held;
    held = folded;
    step(1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h4, 1'b0);
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (valid !== 1'b0 || folded !== held) begin
        miscompares++;
        $display("FAIL restart_scan[%0d]: got valid=%b folded=%h expected 0/%h", k, valid, folded, held);
      end
      step(1'b0, 32'h0, 1'b0);
    end
    exp_f = fold_def(phist);
    vectors++;
    if (valid !== 1'b1 || folded !== exp_f) begin
      miscompares++;
      $display("FAIL restart_done: got folded=%h valid=%b expected %h/1", folded, valid, exp_f);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_f;
    step(1'b1, 32'h0, 1'b1);
    for (int k = 0; k < 15; k++) step(1'b0, 32'h0, 1'b0);
    vectors++;
    if (valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_last_scan: got valid=%b expected 0", valid);
    end
    step(1'b0, 32'h0, 1'b0);
    exp_f = fold_def(phist);
    vectors++;
    if (valid !== 1'b1 || folded !== exp_f) begin
      miscompares++;
      $display("FAIL b2b_done: got folded=%h valid=%b expected %h/1", folded, valid, exp_f);
    end
  endtask

  task automatic test_reset_mid_scan();
    step(1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 8; k++) step(1'b0, 32'h0, 1'b0);
    vectors++;
    if (valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midscan_pre: got valid=%b expected 0", valid);
    end
    rst = 1'b1; wrst = 1'b1;
    #1;
    vectors++;
    if (folded !== 10'h000 || valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midscan_async: got folded=%h valid=%b expected 000/1", folded, valid);
    end
    rst = 1'b0; wrst = 1'b0;
    @(negedge clk);
    step(1'b1, 32'h4, 1'b0);
    vectors++;
    if (folded !== 10'h001 || valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midscan_after: got folded=%h valid=%b expected 001/1", folded, valid);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; wrst = 1'b1;
    we = 1'b0; pc = '0; resync = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_we();
    test_all_ones();
    test_random();
    test_resync();
    test_restart();
    test_back_to_back();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/path_history_folder.md
# path_history_folder

Reader-side companion to the TAGE path-history register. It compresses the PHIST_LEN-bit path history into a FOLD_LEN-bit folded value that TAGE table index and tag hashes use. The value is updated incrementally, one history write per cycle, in lock-step with the history writer. A serial resync state machine recomputes the folded value from the full history on request.

## Interface
- PHIST_LEN, 16: path history length in bits; must match the history writer.
- FOLD_LEN, 10: folded output width; 1 <= FOLD_LEN <= PHIST_LEN.
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- we  input  1  history write strobe; the same signal that drives the history writer's we.
- pc  input  32  PC of the recorded branch; only pc[2] is used, as the new history bit.
- rdata_phist  input  PHIST_LEN  history from the writer; bit 0 is the oldest entry, bit PHIST_LEN-1 the newest.
- resync  input  1  single-cycle request to recompute the folded value from rdata_phist.
- folded  output  FOLD_LEN  folded path history.
- valid  output  1  folded is consistent with the current history.

## Operation
- Definition: folded = XOR over i in 0..PHIST_LEN-1 of (rdata_phist[PHIST_LEN-1-i] << (i mod FOLD_LEN)).
  - i is the age of the bit; the newest bit has age 0.
- States: READY, SCAN.
- Reset:
  - state = READY, folded = 0, valid = 1.
  - This is consistent because the writer also resets its history to all zeros.
- READY, we=1, resync=0:
  - folded <= rotl(folded,1) ^ {0.., pc[2]} ^ (rdata_phist[0] << (PHIST_LEN mod FOLD_LEN)).
  - rdata_phist[0] is sampled in the same cycle as we, i.e. before the writer overwrites that slot.
  - With FOLD_LEN=1 the rotate is the identity.
- READY, resync=1:
  - Go to SCAN; cnt <= 0, acc <= 0, valid <= 0.
  - A simultaneous we is not folded incrementally; the scan sees the updated history.
- SCAN, each cycle with we=0 and resync=0:
  - acc <= rotl(acc,1) ^ rdata_phist[cnt]; cnt <= cnt+1.
  - Bits are processed oldest first.
- SCAN, after the cycle that processes cnt = PHIST_LEN-1:
  - folded <= final acc, valid <= 1, state <= READY.
- SCAN, we=1 or resync=1:
  - Restart: cnt <= 0, acc <= 0, stay in SCAN, valid stays 0.
  - Continuous we can starve the scan; this is accepted, and the predictor must not rely on folded while valid=0.
- During SCAN, folded holds its last READY value.
- cnt is $clog2(PHIST_LEN)+1 bits wide, so it never wraps before the terminal compare.
- All arithmetic is XOR/rotate on FOLD_LEN bits; there is no carry.

## Timing
- Incremental update: folded changes on the clk edge that samples we, i.e. in the same edge as the writer's history update. Latency is 0 extra cycles relative to rdata_phist.
- Resync sampled at edge T:
  - valid = 0 from T.
  - Scan cycles run T+1 .. T+PHIST_LEN.
  - folded is correct and valid = 1 after edge T+PHIST_LEN.
  - Total: exactly PHIST_LEN+1 edges when no restart occurs.
- A restart at edge R pushes completion to R+PHIST_LEN.
- Asynchronous reset mid-SCAN forces READY, folded = 0 and valid = 1 immediately, without waiting for a clock edge.
- Outputs are registered; there is no combinational path from any input to folded or valid.

## Test plan
All scenarios use PHIST_LEN=16, FOLD_LEN=10, with the folder instantiated alongside the history writer.
- Reset, then one we with pc=0x4 -> folded=10'h001, valid=1.
- Reset, then 16 consecutive we with pc[2]=1 -> folded=10'h3C0 (positions 6..9 set, 0..5 cancel). Then 10 more with pc[2]=1 -> folded still 10'h3C0.
- 200 random we/pc, checked every cycle against the definition computed from rdata_phist -> exact match whenever valid=1.
- Random history, then a resync pulse with we held low -> valid low for 16 cycles, then valid=1 and folded equals the definition.
- resync, then we on scan cycle 5 -> valid stays low until 16 cycles after that we. The final value matches the definition.
- Assert rst on scan cycle 8 -> folded=0, valid=1, state READY with no clock edge needed. The next we behaves as in the first scenario.
